spi_word_bridge: RTL

- Parametrised successor to the single-byte SPI echo driver.
- Sits between the existing byte-level SPI slave engine and miner logic.
- Assembles received bytes MSB-first into WORD_BYTES-wide words and buffers them in an RX FIFO.
- Serialises words from a TX FIFO back out one byte per data_needed request, honours frame boundaries from chip select, and reports sticky error flags.

---
 rtl/spi_word_bridge.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/spi_word_bridge.sv
// Word-level bridge between the byte-oriented SPI slave engine and the miner logic.
// It packs RX bytes MSB-first into words, unpacks TX words into bytes, and keeps sticky error flags.
module spi_word_bridge #(
   parameter int             WORD_BYTES      = 4,
   parameter int             DEPTH           = 4,
   parameter logic [7:0]     FILL_BYTE       = 8'hFF,
   parameter bit             ECHO_WHEN_EMPTY = 1'b1,
   localparam int            W               = 8 * WORD_BYTES,
   localparam int            CW              = $clog2(DEPTH + 1)
) (
   input  logic          CLK_3_33_MHZ,
   input  logic          rst_n,
   input  logic          ssel,
   input  logic          byte_received,
   input  logic [7:0]    received_data,
   input  logic          data_needed,
   output logic [7:0]    data_to_send,
   output logic [W-1:0]  rx_word,
   output logic          rx_valid,
   input  logic          rx_ready,
   output logic [CW-1:0] rx_count,
   input  logic [W-1:0]  tx_word,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic          rx_overflow,
   output logic          tx_underrun,
   output logic          short_frame,
   input  logic          err_clear
);

   localparam int             IW       = $clog2(WORD_BYTES);
   localparam int             PW       = $clog2(DEPTH);
   localparam logic [IW-1:0]  LAST_IDX = IW'(WORD_BYTES - 1);
   localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

   // Chip select synchroniser; idles high so reset release never fakes a frame end.
   logic ssel_m, ssel_s, ssel_d;
   logic frame_end;

   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         ssel_m <= 1'b1;
         ssel_s <= 1'b1;
         ssel_d <= 1'b1;
      end else begin
         ssel_m <= ssel;
         ssel_s <= ssel_m;
         ssel_d <= ssel_s;
      end
   end

   assign frame_end = ssel_s & ~ssel_d;

   // Frame end takes priority over any byte event in the same cycle.
   logic          rx_byte, tx_req;
   logic [IW-1:0] rx_idx, tx_idx;
   logic [W-1:0]  asm_q, new_word, sh;
   logic [7:0]    last_rx;
   logic          word_done;

   assign rx_byte   = byte_received & ~frame_end;
   assign tx_req    = data_needed & ~frame_end;
   assign new_word  = {asm_q[W-9:0], received_data};
   assign word_done = rx_byte && (rx_idx == LAST_IDX);

   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         asm_q   <= '0;
         rx_idx  <= '0;
         last_rx <= FILL_BYTE;
      end else if (frame_end) begin
         asm_q  <= '0;
         rx_idx <= '0;
      end else if (byte_received) begin
         asm_q   <= new_word;
         last_rx <= received_data;
         rx_idx  <= word_done ? '0 : rx_idx + 1'b1;
      end
   end

   // Both FIFOs use valid/ready: a transfer happens on a cycle where valid && ready are both high;
   // the producer holds data stable while valid && !ready, and the consumer may drop ready freely.
   logic [W-1:0]  rx_mem [DEPTH];
   logic [PW-1:0] rx_wr, rx_rd;
   logic [CW-1:0] rx_cnt;
   logic          rx_push, rx_pop, rx_drop;

   assign rx_valid = (rx_cnt != '0);
   assign rx_pop   = rx_valid & rx_ready;
   assign rx_push  = word_done && ((rx_cnt != FULL_CNT) || rx_pop);
   assign rx_drop  = word_done && (rx_cnt == FULL_CNT) && !rx_pop;
   assign rx_word  = rx_valid ? rx_mem[rx_rd] : '0;
   assign rx_count = rx_cnt;

   always_ff @(posedge CLK_3_33_MHZ) begin
      if (rx_push) rx_mem[rx_wr] <= new_word;
   end

   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         rx_wr  <= '0;
         rx_rd  <= '0;
         rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wr <= rx_wr + 1'b1;
         if (rx_pop)  rx_rd <= rx_rd + 1'b1;
         if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
         else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - 1'b1;
      end
   end

   logic [W-1:0]  tx_mem [DEPTH];
   logic [PW-1:0] tx_wr, tx_rd;
   logic [CW-1:0] tx_cnt;
   logic          tx_push, tx_pop, tx_empty_req;
   logic [W-1:0]  tx_head;

   assign tx_ready     = (tx_cnt != FULL_CNT);
   assign tx_push      = tx_valid & tx_ready;
   assign tx_head      = tx_mem[tx_rd];
   assign tx_pop       = tx_req && (tx_idx == '0) && (tx_cnt != '0);
   assign tx_empty_req = tx_req && (tx_idx == '0) && (tx_cnt == '0);

   always_ff @(posedge CLK_3_33_MHZ) begin
      if (tx_push) tx_mem[tx_wr] <= tx_word;
   end

   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         tx_wr  <= '0;
         tx_rd  <= '0;
         tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wr <= tx_wr + 1'b1;
         if (tx_pop)  tx_rd <= tx_rd + 1'b1;
         if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
         else if (tx_pop && !tx_push) tx_cnt <= tx_cnt - 1'b1;
      end
   end

   // Serialiser: sh always holds the not-yet-sent bytes left-aligned.
   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         data_to_send <= FILL_BYTE;
         sh           <= '0;
         tx_idx       <= '0;
      end else if (frame_end) begin
         tx_idx <= '0;
      end else if (tx_pop) begin
         data_to_send <= tx_head[W-1:W-8];
         sh           <= {tx_head[W-9:0], 8'h00};
         tx_idx       <= IW'(1);
      end else if (tx_empty_req) begin
         data_to_send <= ECHO_WHEN_EMPTY ? last_rx : FILL_BYTE;
      end else if (tx_req) begin
         data_to_send <= sh[W-1:W-8];
         sh           <= {sh[W-9:0], 8'h00};
         tx_idx       <= (tx_idx == LAST_IDX) ? '0 : tx_idx + 1'b1;
      end
   end

   always_ff @(posedge CLK_3_33_MHZ or negedge rst_n) begin
      if (!rst_n) begin
         rx_overflow <= 1'b0;
         tx_underrun <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         rx_overflow <= (rx_overflow & ~err_clear) | rx_drop;
         tx_underrun <= (tx_underrun & ~err_clear) | tx_empty_req;
         short_frame <= (short_frame & ~err_clear) | (frame_end && (rx_idx != '0));
      end
   end

endmodule
